lsu_mem_ctrl: RTL and testbench

Load/store initiator that drives the data port of the word-addressed, synchronous-read data RAM. It accepts byte/halfword/word requests with byte addresses from the CPU memory stage over a valid/ready handshake, performs the RAM cycles, and returns a valid/ready response. Loads are sign- or zero-extended. Sub-word stores use a read-modify-write sequence. Misaligned, out-of-range or illegal-size requests return an error and never touch the RAM.

---
 rtl/lsu_mem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller for the synchronous-read, word-addressed data RAM.
// One transaction at a time; sub-word stores are done as read-modify-write.
module lsu_mem_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_write_en,
  output logic [AW-1:0]     ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MERGE,
    WR,
    RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t            state;
  logic              lat_we;
  logic [1:0]        lat_size;
  logic              lat_uns;
  logic [1:0]        lat_off;
  logic [15:0]       lat_wdata;

  logic [ADDR_W-1:0] word_idx;
  logic              req_bad;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;

  // Request legality is decided on the raw inputs so an error never reaches the RAM.
  always_comb begin
    word_idx = req_addr >> 2;
    req_bad  = 1'b0;
    case (req_size)
      SZ_HALF: req_bad = req_addr[0];
      SZ_WORD: req_bad = |req_addr[1:0];
      SZ_BYTE: req_bad = 1'b0;
      default: req_bad = 1'b1;
    endcase
    if (word_idx >= ADDR_W'(DEPTH)) begin
      req_bad = 1'b1;
    end
  end

  always_comb begin
    sel_byte = ram_rdata[{lat_off, 3'b000} +: 8];
    sel_half = ram_rdata[{lat_off[1], 4'b0000} +: 16];
    case (lat_size)
      SZ_BYTE: load_data = lat_uns ? {24'h000000, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      SZ_HALF: load_data = lat_uns ? {16'h0000, sel_half}   : {{16{sel_half[15]}}, sel_half};
      default: load_data = ram_rdata;
    endcase
    merge_data = ram_rdata;
    if (lat_size == SZ_BYTE) begin
      merge_data[{lat_off, 3'b000} +: 8] = lat_wdata[7:0];
    end else if (lat_size == SZ_HALF) begin
      merge_data[{lat_off[1], 4'b0000} +: 16] = lat_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= '0;
      ram_write_en <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      lat_we       <= 1'b0;
      lat_size     <= '0;
      lat_uns      <= 1'b0;
      lat_off      <= '0;
      lat_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            lat_we    <= req_we;
            lat_size  <= req_size;
            lat_uns   <= req_unsigned;
            lat_off   <= req_addr[1:0];
            lat_wdata <= req_wdata[15:0];
            if (req_bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              ram_addr <= req_addr[AW+1:2];
              if (req_we && (req_size == SZ_WORD)) begin
                state        <= WR;
                ram_wdata    <= req_wdata;
                ram_write_en <= 1'b1;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: begin
          state <= MERGE;
        end
        MERGE: begin
          if (lat_we) begin
            state        <= WR;
            ram_wdata    <= merge_data;
            ram_write_en <= 1'b1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_data;
          end
        end
        WR: begin
          state        <= RESP;
          ram_write_en <= 1'b0;
          resp_valid   <= 1'b1;
          resp_err     <= 1'b0;
          resp_rdata   <= '0;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          req_ready    <= 1'b1;
          resp_valid   <= 1'b0;
          ram_write_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl with a behavioural synchronous-read RAM.
module tb_lsu_mem_ctrl;

  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          ram_write_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  logic [31:0] mem [DEPTH] = '{default: '0};

  lsu_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .ram_write_en (ram_write_en),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_write_en) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int unsigned exp_lat;
    int unsigned exp_wr;
    int unsigned hold;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
    int unsigned wr;
  } exp_t;

  vec_t vecs[$];
  exp_t scb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int unsigned exp_lat, input int unsigned exp_wr,
                              input int unsigned hold);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_wr = exp_wr; v.hold = hold;
    return v;
  endfunction

  // Drive a request at a falling edge and return just after the accepting rising edge.
  task automatic start_req(input vec_t v, output logic ok);
    int unsigned n;
    @(negedge clock);
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    ok = req_ready;
    check("accept_timeout", {31'b0, req_ready}, 32'd1);
    if (ok) @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input int unsigned idx);
    exp_t        e;
    exp_t        got;
    logic        ok;
    logic        seen;
    logic        done;
    int unsigned k;
    int unsigned held;
    logic [AW-1:0] waddr;
    waddr = v.addr[AW+1:2];
    resp_ready = (v.hold == 0);
    start_req(v, ok);
    if (!ok) return;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat; e.wr = v.exp_wr;
    scb.push_back(e);
    check($sformatf("v%0d_ready_low", idx), {31'b0, req_ready}, 32'd0);
    got.wr = 0; got.lat = 0; got.rdata = '0; got.err = 1'b0;
    seen = 1'b0; done = 1'b0; held = 0; k = 0;
    while (!done && k < 60) begin
      if (ram_write_en) begin
        got.wr++;
        check($sformatf("v%0d_waddr", idx), 32'(ram_addr), 32'(waddr));
      end
      if (resp_valid) begin
        if (!seen) begin
          seen = 1'b1;
          got.lat = k;
        end
        got.rdata = resp_rdata;
        got.err = resp_err;
        if (resp_ready) begin
          done = 1'b1;
        end else begin
          check($sformatf("v%0d_hold_rdata", idx), resp_rdata, v.exp_rdata);
          check($sformatf("v%0d_hold_ready", idx), {31'b0, req_ready}, 32'd0);
          held++;
          if (held >= v.hold) begin
            resp_ready = 1'b1;
            done = 1'b1;
          end
        end
      end
      if (!done) begin
        @(posedge clock);
        #1;
        k++;
      end
    end
    check($sformatf("v%0d_resp_timeout", idx), {31'b0, done}, 32'd1);
    e = scb.pop_front();
    check($sformatf("v%0d_rdata", idx), got.rdata, e.rdata);
    check($sformatf("v%0d_err", idx), {31'b0, got.err}, {31'b0, e.err});
    check($sformatf("v%0d_latency", idx), got.lat, e.lat);
    check($sformatf("v%0d_writes", idx), got.wr, e.wr);
    @(posedge clock);
    #1;
    check($sformatf("v%0d_idle_ready", idx), {31'b0, req_ready}, 32'd1);
    check($sformatf("v%0d_idle_valid", idx), {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_resp_err"}, {31'b0, resp_err}, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_write_en"}, {31'b0, ram_write_en}, 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
  endtask

  task automatic quiet_cycles(input string tag, input int unsigned n);
    int unsigned wr;
    int unsigned rv;
    wr = 0; rv = 0;
    repeat (n) begin
      @(posedge clock);
      #1;
      if (ram_write_en) wr++;
      if (resp_valid) rv++;
    end
    check({tag, "_no_write"}, wr, 32'd0);
    check({tag, "_no_resp"}, rv, 32'd0);
  endtask

  localparam logic [31:0] TOP = 32'(4 * DEPTH);

  initial begin
    vec_t v;
    logic ok;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;

    //        we size uns addr        wdata          exp_rdata      err lat wr hold
    vecs.push_back(mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1, 1, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 0, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h10, 32'h80FF7F01, 32'h0,        0, 1, 1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h13, 32'h0,        32'hFFFFFF80, 0, 2, 0, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h13, 32'h0,        32'h00000080, 0, 2, 0, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h12, 32'h0,        32'hFFFF80FF, 0, 2, 0, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h10, 32'h0,        32'h00007F01, 0, 2, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h11, 32'h0,        32'h0000007F, 0, 2, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h12, 32'h0,        32'hFFFFFFFF, 0, 2, 0, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0,        0, 1, 1, 0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h11, 32'hFFFFFFAA, 32'h0,        0, 3, 1, 0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h12, 32'h1234BEEF, 32'h0,        0, 3, 1, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        32'hBEEFAA44, 0, 2, 0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        32'hBEEFAA44, 0, 2, 0, 5));
    vecs.push_back(mk(0, 2'b10, 0, 32'h12, 32'h0,        32'h0,        1, 0, 0, 0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h11, 32'h0000FFFF, 32'h0,        1, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 32'h10, 32'h0,        32'h0,        1, 0, 0, 0));
    vecs.push_back(mk(1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, 32'h0,        1, 0, 0, 0));
    vecs.push_back(mk(0, 2'b10, 0, TOP,    32'h0,        32'h0,        1, 0, 0, 0));
    vecs.push_back(mk(1, 2'b10, 0, TOP,    32'h12345678, 32'h0,        1, 0, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, TOP-1,  32'h0000005A, 32'h0,        0, 3, 1, 0));
    vecs.push_back(mk(0, 2'b00, 1, TOP-1,  32'h0,        32'h0000005A, 0, 2, 0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        32'hBEEFAA44, 0, 2, 0, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 32'h0,        0, 1, 1, 0));

    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i], i);
    check("mem_word4", mem[4], 32'hBEEFAA44);
    check("mem_top", mem[DEPTH-1], 32'h5A000000);

    // Reset while MERGE of a byte store: transaction dropped, no write.
    resp_ready = 1'b1;
    v = mk(1, 2'b00, 0, 32'h21, 32'h00000077, 32'h0, 0, 3, 1, 0);
    start_req(v, ok);
    @(posedge clock);
    #1;
    check("rstA_merge_we", {31'b0, ram_write_en}, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_reset_outputs("rstA");
    @(negedge clock);
    reset = 1'b0;
    quiet_cycles("rstA", 6);
    check("rstA_mem", mem[8], 32'hCAFEF00D);

    // Reset on the edge ending WR: the write still lands, no response.
    start_req(v, ok);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    check("rstB_wr_we", {31'b0, ram_write_en}, 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_reset_outputs("rstB");
    @(negedge clock);
    reset = 1'b0;
    quiet_cycles("rstB", 6);
    check("rstB_mem", mem[8], 32'hCAFE770D);

    run_txn(mk(0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFE770D, 0, 2, 0, 0), 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
